// File: rtl/carry_save_mult_seq.sv
// carry_save_mult_seq: sequential carry-save multiplier, one 3:2 row per cycle, ripple merge, valid/ready both sides (signed Baugh-Wooley when CSM_SIGNED_EN is defined)
module carry_save_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   factor1,
  input  logic [WIDTH-1:0]   factor2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int RW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, MERGE, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b, lo;
  logic [WIDTH:0] sum, carry, pp, s, c;
  logic [RW-1:0] row;
  logic last;
  always_comb begin
    last = row == RW'(WIDTH - 1);
`ifdef CSM_SIGNED_EN
    pp = {1'b0, (a & {WIDTH{b[0]}}) ^ (last ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}})};
`else
    pp = {1'b0, a & {WIDTH{b[0]}}};
`endif
    s = pp ^ sum ^ carry;
    c = (pp & sum) | (pp & carry) | (sum & carry);
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = (state == ACCUM) || (state == MERGE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      lo      <= '0;
      sum     <= '0;
      carry   <= '0;
      row     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a     <= factor1;
          b     <= factor2;
          sum   <= '0;
`ifdef CSM_SIGNED_EN
          carry <= {1'b1, {WIDTH{1'b0}}};
`else
          carry <= '0;
`endif
          row   <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          lo  <= {s[0], lo[WIDTH-1:1]};
          sum <= {1'b0, s[WIDTH:1]};
`ifdef CSM_SIGNED_EN
          carry <= {c[WIDTH] | (row == RW'(WIDTH - 2)), c[WIDTH-1:0]};
`else
          carry <= c;
`endif
          b     <= b >> 1;
          row   <= row + 1'b1;
          state <= last ? MERGE : ACCUM;
        end
        MERGE: begin
          product <= {sum[WIDTH-1:0] + carry[WIDTH-1:0], lo};
          state   <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
